// File: rtl/alu_pipe_if.sv
// Handshake bundle for the pipelined ALU. The issue side drives in_*, and the
// writeback side consumes out_* and drives out_ready back.
interface alu_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_wr_en;
  logic             out_carry;
  logic             out_zero;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_wr_en, out_carry, out_zero
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_wr_en, out_carry, out_zero
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU. It holds the architectural C/Z flags and evaluates
// the conditional ops against them. Valid/ready handshakes are used on both sides.
module alu_pipe #(
  parameter int WIDTH          = 16,
  parameter int ADL_SHIFT      = 1,
  parameter int SUB_SETS_CARRY = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  alu_pipe_if.slave  bus
);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADZ = 3'b001;
  localparam logic [2:0] OP_ADC = 3'b010;
  localparam logic [2:0] OP_ADL = 3'b011;
  localparam logic [2:0] OP_NDU = 3'b100;
  localparam logic [2:0] OP_NDZ = 3'b101;
  localparam logic [2:0] OP_NDC = 3'b110;
  localparam logic [2:0] OP_SUB = 3'b111;

  logic             r_s1_valid;
  logic [2:0]       r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_result;
  logic             r_s2_wr_en;

  logic             r_c;
  logic             r_z;

  logic             w_adv2;
  logic             w_adv1;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_xfer;

  logic [WIDTH-1:0] w_b_shl;
  logic [WIDTH:0]   w_sum_add;
  logic [WIDTH:0]   w_sum_adl;
  logic [WIDTH:0]   w_sum_sub;
  logic [WIDTH-1:0] w_nand;

  logic [WIDTH-1:0] w_res;
  logic             w_cout;
  logic             w_exec;
  logic             w_c_next;
  logic             w_z_next;

  // S1 and S2 advance together, so a full pipe still sustains one op per cycle.
  assign w_adv2     = !r_s2_valid || bus.out_ready;
  assign w_adv1     = w_adv2;
  assign w_in_ready = (!r_s1_valid || w_adv1) && !flush;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_xfer     = w_adv1 && r_s1_valid && !flush;

  assign w_b_shl   = r_s1_b << ADL_SHIFT;
  assign w_sum_add = {1'b0, r_s1_a} + {1'b0, r_s1_b};
  assign w_sum_adl = {1'b0, r_s1_a} + {1'b0, w_b_shl};
  assign w_sum_sub = {1'b0, r_s1_a} + {1'b0, ~r_s1_b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_nand    = ~(r_s1_a & r_s1_b);

  always_comb begin
    w_res    = w_sum_add[WIDTH-1:0];
    w_cout   = w_sum_add[WIDTH];
    w_exec   = 1'b1;
    w_c_next = r_c;
    case (r_s1_op)
      OP_ADD: begin
        w_c_next = w_cout;
      end
      OP_ADZ: begin
        w_exec   = r_z;
        w_c_next = w_cout;
      end
      OP_ADC: begin
        w_exec   = r_c;
        w_c_next = w_cout;
      end
      OP_ADL: begin
        w_res    = w_sum_adl[WIDTH-1:0];
        w_cout   = w_sum_adl[WIDTH];
        w_c_next = w_cout;
      end
      OP_NDU: begin
        w_res = w_nand;
      end
      OP_NDZ: begin
        w_res  = w_nand;
        w_exec = r_z;
      end
      OP_NDC: begin
        w_res  = w_nand;
        w_exec = r_c;
      end
      OP_SUB: begin
        w_res    = w_sum_sub[WIDTH-1:0];
        w_cout   = w_sum_sub[WIDTH];
        w_c_next = (SUB_SETS_CARRY != 0) ? w_cout : r_c;
      end
      default: begin
        w_exec = 1'b1;
      end
    endcase
    // A skipped op still produces its result, but it leaves both flags untouched.
    if (!w_exec) begin
      w_c_next = r_c;
    end
    w_z_next = w_exec ? (w_res == '0) : r_z;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_op     <= '0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_wr_en  <= 1'b0;
      r_c         <= 1'b0;
      r_z         <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_in_ready) begin
        r_s1_valid <= bus.in_valid;
      end
      if (w_accept) begin
        r_s1_op <= bus.in_op;
        r_s1_a  <= bus.in_a;
        r_s1_b  <= bus.in_b;
      end
      if (w_adv2) begin
        r_s2_valid <= r_s1_valid;
      end
      // The flags change only when an op moves into S2, so a stalled pipe holds them.
      if (w_xfer) begin
        r_s2_result <= w_res;
        r_s2_wr_en  <= w_exec;
        r_c         <= w_c_next;
        r_z         <= w_z_next;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_s2_valid;
  assign bus.out_result = r_s2_result;
  assign bus.out_wr_en  = r_s2_wr_en;
  assign bus.out_carry  = r_c;
  assign bus.out_zero   = r_z;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed scoreboard bench for alu_pipe. Two instances differ only in SUB_SETS_CARRY.
// Expected responses are queued at issue and checked by per-instance monitors.
module tb_alu_pipe;
  localparam logic [2:0] ADD = 3'b000, ADZ = 3'b001, ADC = 3'b010, ADL = 3'b011;
  localparam logic [2:0] NDU = 3'b100, NDZ = 3'b101, NDC = 3'b110, SUB = 3'b111;

  typedef struct packed {
    logic [15:0] res;
    logic        wr;
    logic        c;
    logic        z;
  } exp_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        wr;
    logic        c0;
    logic        z;
    logic        c1;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [2:0]  in_op;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_ready;

  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0;
  exp_t e1;

  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(16)) if0 ();
  alu_pipe_if #(.WIDTH(16)) if1 ();

  assign if0.in_valid  = in_valid;
  assign if0.in_op     = in_op;
  assign if0.in_a      = in_a;
  assign if0.in_b      = in_b;
  assign if0.out_ready = out_ready;
  assign if1.in_valid  = in_valid;
  assign if1.in_op     = in_op;
  assign if1.in_a      = in_a;
  assign if1.in_b      = in_b;
  assign if1.out_ready = out_ready;

  alu_pipe #(.WIDTH(16), .ADL_SHIFT(1), .SUB_SETS_CARRY(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .bus(if0.slave)
  );
  alu_pipe #(.WIDTH(16), .ADL_SHIFT(1), .SUB_SETS_CARRY(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .bus(if1.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && if0.out_valid && if0.out_ready) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut0_unexpected actual=%h required=no output", if0.out_result);
      end else begin
        e0 = q0.pop_front();
        check("dut0_result", 32'(if0.out_result), 32'(e0.res));
        check("dut0_wr_en", 32'(if0.out_wr_en), 32'(e0.wr));
        check("dut0_carry", 32'(if0.out_carry), 32'(e0.c));
        check("dut0_zero", 32'(if0.out_zero), 32'(e0.z));
        $display("dut0 txn result=%h wr_en=%b c=%b z=%b", if0.out_result, if0.out_wr_en,
                 if0.out_carry, if0.out_zero);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && if1.out_valid && if1.out_ready) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1_unexpected actual=%h required=no output", if1.out_result);
      end else begin
        e1 = q1.pop_front();
        check("dut1_result", 32'(if1.out_result), 32'(e1.res));
        check("dut1_wr_en", 32'(if1.out_wr_en), 32'(e1.wr));
        check("dut1_carry", 32'(if1.out_carry), 32'(e1.c));
        check("dut1_zero", 32'(if1.out_zero), 32'(e1.z));
        $display("dut1 txn result=%h wr_en=%b c=%b z=%b", if1.out_result, if1.out_wr_en,
                 if1.out_carry, if1.out_zero);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the op is accepted.
  task automatic issue(input vec_t v);
    bit ok = 1'b0;
    in_op    = v.op;
    in_a     = v.a;
    in_b     = v.b;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (if0.in_ready && if1.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout actual=in_ready 0 required=1 op=%0d", v.op);
    end else begin
      q0.push_back('{res: v.res, wr: v.wr, c: v.c0, z: v.z});
      q1.push_back('{res: v.res, wr: v.wr, c: v.c1, z: v.z});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100; k++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(posedge clk);
      #1;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d/%0d pending required=0", q0.size(), q1.size());
    end
  endtask

  task automatic check_both(input string name, input logic a0, input logic a1, input logic req);
    check({name, "_dut0"}, 32'(a0), 32'(req));
    check({name, "_dut1"}, 32'(a1), 32'(req));
  endtask

  vec_t seq_a[3];
  vec_t seq_b[8];

  initial begin
    // op, a, b, result, wr_en, C(dut0), Z, C(dut1)
    seq_a[0] = '{ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1};
    seq_a[1] = '{ADC, 16'h0002, 16'h0003, 16'h0005, 1'b1, 1'b0, 1'b0, 1'b0};
    seq_a[2] = '{NDC, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    seq_b[0] = '{SUB, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};
    seq_b[1] = '{ADL, 16'h0001, 16'h0003, 16'h0007, 1'b1, 1'b0, 1'b0, 1'b0};
    seq_b[2] = '{ADZ, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0};
    seq_b[3] = '{NDU, 16'h00FF, 16'h0F0F, 16'hFFF0, 1'b1, 1'b0, 1'b0, 1'b0};
    seq_b[4] = '{SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0};
    seq_b[5] = '{ADD, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1};
    seq_b[6] = '{NDZ, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1};
    seq_b[7] = '{ADC, 16'h0001, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_both("rst_out_valid", if0.out_valid, if1.out_valid, 1'b0);
    check("rst_result_dut0", 32'(if0.out_result), 32'h0);
    check_both("rst_wr_en", if0.out_wr_en, if1.out_wr_en, 1'b0);
    check_both("rst_carry", if0.out_carry, if1.out_carry, 1'b0);
    check_both("rst_zero", if0.out_zero, if1.out_zero, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_both("rst_in_ready", if0.in_ready, if1.in_ready, 1'b1);

    // Reset while an op waits in S2 must drop it at once and clear the flags.
    issue(seq_a[0]);
    wait_drain();
    out_ready = 1'b0;
    issue(seq_b[5]);
    @(posedge clk);
    #1;
    check_both("pre_reset_valid", if0.out_valid, if1.out_valid, 1'b1);
    check_both("pre_reset_carry", if0.out_carry, if1.out_carry, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_both("midrst_out_valid", if0.out_valid, if1.out_valid, 1'b0);
    check_both("midrst_carry", if0.out_carry, if1.out_carry, 1'b0);
    check_both("midrst_zero", if0.out_zero, if1.out_zero, 1'b0);
    check("midrst_result_dut0", 32'(if0.out_result), 32'h0);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    check_both("postrst_in_ready", if0.in_ready, if1.in_ready, 1'b1);

    foreach (seq_a[i]) issue(seq_a[i]);
    wait_drain();

    // Backpressure: two ops fill the pipe, and the third waits until the consumer returns.
    out_ready = 1'b0;
    issue('{ADD, 16'h0001, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0});
    issue('{ADD, 16'h0002, 16'h0002, 16'h0004, 1'b1, 1'b0, 1'b0, 1'b0});
    check_both("bp_in_ready", if0.in_ready, if1.in_ready, 1'b0);
    check_both("bp_out_valid", if0.out_valid, if1.out_valid, 1'b1);
    fork
      issue('{ADD, 16'h0003, 16'h0003, 16'h0006, 1'b1, 1'b0, 1'b0, 1'b0});
      begin
        repeat (2) begin
          @(posedge clk);
          #1;
          check("bp_hold_result_dut0", 32'(if0.out_result), 32'h0002);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    foreach (seq_b[i]) issue(seq_b[i]);
    wait_drain();

    // Flush with one op in S2 (already flagged) and one in S1; a new op is offered too.
    out_ready = 1'b0;
    issue('{ADD, 16'h8000, 16'h8001, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b1});
    issue('{ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1});
    flush = 1'b1;
    in_valid = 1'b1;
    in_op = ADD;
    in_a = 16'h0007;
    in_b = 16'h0000;
    #1;
    check_both("flush_in_ready", if0.in_ready, if1.in_ready, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check_both("flush_out_valid", if0.out_valid, if1.out_valid, 1'b0);
    check_both("flush_carry", if0.out_carry, if1.out_carry, 1'b1);
    check_both("flush_zero", if0.out_zero, if1.out_zero, 1'b0);
    q0.delete();
    q1.delete();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_both("flush_stays_empty", if0.out_valid, if1.out_valid, 1'b0);
    issue('{ADZ, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b1});
    issue('{ADC, 16'h0001, 16'h0002, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b0});
    wait_drain();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
